// File: rtl/seg_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl_pkg
// Shared constants for the multiplexed seven-segment scan controller:
// the BCD digit width, the all-segments-off pattern and the two scan
// state encodings used by the per-slot FSM.
// No ports (package).
// ---------------------------------------------------------------------------
package seg_scan_ctrl_pkg;

    // Width of one packed BCD digit
    localparam int DIGIT_W = 4;

    // Segment pattern with every segment (and the decimal point) dark
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Per-slot scan states: anti-ghosting blank window, then the lit digit
    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

endpackage

// File: rtl/seg_scan_ctrl_bcd_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl_bcd_decoder
// Purely combinational BCD to seven-segment decoder, active-high segments,
// output ordered {dp,g,f,e,d,c,b,a}. Codes 10..15 decode to all-off and the
// decimal point is never lit.
// Ports:
//   bcd_i  in  4  BCD digit code
//   seg_o  out 8  segment pattern {dp,g..a}
// ---------------------------------------------------------------------------
module seg_scan_ctrl_bcd_decoder
    import seg_scan_ctrl_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd_i,
    output logic [7:0]         seg_o
);

    // Classic segment table; anything outside 0..9 is shown as dark
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = 8'h3F;
            4'd1:    seg_o = 8'h06;
            4'd2:    seg_o = 8'h5B;
            4'd3:    seg_o = 8'h4F;
            4'd4:    seg_o = 8'h66;
            4'd5:    seg_o = 8'h6D;
            4'd6:    seg_o = 8'h7D;
            4'd7:    seg_o = 8'h07;
            4'd8:    seg_o = 8'h7F;
            4'd9:    seg_o = 8'h6F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexes NUM_DIGITS BCD digits through one shared decoder onto a
// common-segment display. New values are double-buffered behind a
// valid/ready handshake and only swapped in at a frame boundary, so a frame
// never shows a mix of old and new digits. Each digit slot starts with a
// short window where all digit enables are off to avoid ghosting, and
// leading zeros can optionally be blanked.
// Ports:
//   clk         in   1              system clock
//   reset       in   1              synchronous, active-high reset
//   i_valid     in   1              load request, taken when i_valid & o_ready
//   o_ready     out  1              shadow register free (no update pending)
//   i_value     in   4*NUM_DIGITS   packed BCD, [3:0] is digit 0
//   i_blank_lz  in   1              blank leading zeros (used live)
//   o_seg       out  8              segments of the current digit {dp,g..a}
//   o_digit_en  out  NUM_DIGITS     one-hot digit enable, 0 in blank window
//   o_frame     out  1              pulse with the first output of digit 0
// ---------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] i_value,
    input  logic                          i_blank_lz,
    output logic [7:0]                    o_seg,
    output logic [NUM_DIGITS-1:0]         o_digit_en,
    output logic                          o_frame
);

    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int VAL_W = DIGIT_W * NUM_DIGITS;

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST =
        CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] DIGIT_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [0:0]       ST_FIRST   = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

    logic [CNT_W-1:0]      slotCnt_q,  slotCnt_d;
    logic [IDX_W-1:0]      digitIdx_q, digitIdx_d;
    logic [0:0]            state_q,    state_d;
    logic [VAL_W-1:0]      shadow_q,   shadow_d;
    logic [VAL_W-1:0]      active_q,   active_d;
    logic                  pending_q,  pending_d;
    logic [7:0]            seg_q,      seg_d;
    logic [NUM_DIGITS-1:0] digitEn_q,  digitEn_d;
    logic                  frame_q,    frame_d;
    logic                  ready_q,    ready_d;

    logic                  slotWrap;
    logic                  frameStart;
    logic                  accept;
    logic                  transfer;
    logic [VAL_W-1:0]      dispValue;
    logic [DIGIT_W-1:0]    curDigit;
    logic                  suppress;
    logic [NUM_DIGITS-1:0] oneHot;
    logic [7:0]            decSeg;

    // Slot timing, digit rotation and the per-slot blank/show FSM.
    // The FSM state always mirrors whether slotCnt_q is inside the blank
    // window; with no window it simply never leaves SHOW.
    always_comb begin
        slotWrap   = (slotCnt_q == SLOT_LAST);
        frameStart = (slotCnt_q == '0) && (digitIdx_q == '0);

        slotCnt_d  = slotWrap ? '0 : slotCnt_q + 1'b1;
        digitIdx_d = digitIdx_q;
        if (slotWrap) begin
            digitIdx_d = (digitIdx_q == DIGIT_LAST) ? '0 : digitIdx_q + 1'b1;
        end

        state_d = state_q;
        if (BLANK_CYCLES == 0) begin
            state_d = ST_SHOW;
        end else if (slotWrap) begin
            state_d = ST_BLANK;
        end else if ((state_q == ST_BLANK) && (slotCnt_q == BLANK_LAST)) begin
            state_d = ST_SHOW;
        end
    end

    // Load handshake and double buffer. A pending value is promoted at the
    // frame boundary and is already used for decoding in that same cycle,
    // so the first digit of the frame shows the new value. ready is low
    // whenever something is pending, so a load can never collide with a
    // transfer; a load taken in the boundary cycle waits a whole frame.
    always_comb begin
        accept    = i_valid && ready_q;
        transfer  = frameStart && pending_q;

        shadow_d  = accept   ? i_value  : shadow_q;
        active_d  = transfer ? shadow_q : active_q;
        pending_d = pending_q;
        if (transfer) begin
            pending_d = 1'b0;
        end else if (accept) begin
            pending_d = 1'b1;
        end
        ready_d   = ~pending_d;

        dispValue = transfer ? shadow_q : active_q;
    end

    // Digit selection and leading-zero mask. Walking from the top digit
    // down, a digit is a leading zero while every digit above it (and
    // itself) is zero; digit 0 is never treated as one. Codes 10..15 are
    // non-zero here, so they stop the run of leading zeros.
    always_comb begin
        logic allZero;
        allZero  = 1'b1;
        curDigit = '0;
        suppress = 1'b0;
        oneHot   = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            allZero = allZero && (dispValue[k*DIGIT_W +: DIGIT_W] == '0);
            if (digitIdx_q == IDX_W'(k)) begin
                curDigit  = dispValue[k*DIGIT_W +: DIGIT_W];
                suppress  = i_blank_lz && allZero && (k != 0);
                oneHot[k] = 1'b1;
            end
        end
    end

    seg_scan_ctrl_bcd_decoder u_decoder (
        .bcd_i (curDigit),
        .seg_o (decSeg)
    );

    // Output stage: everything the pins see comes straight from a flop.
    // Segments are driven during the blank window too, so they have
    // settled before the digit enable turns on.
    always_comb begin
        seg_d     = suppress ? SEG_BLANK : decSeg;
        digitEn_d = (state_q == ST_SHOW) ? oneHot : '0;
        frame_d   = frameStart;
    end

    // State and output registers with synchronous reset; reset drops any
    // pending update and restarts the scan at digit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            slotCnt_q  <= '0;
            digitIdx_q <= '0;
            state_q    <= ST_FIRST;
            shadow_q   <= '0;
            active_q   <= '0;
            pending_q  <= 1'b0;
            seg_q      <= SEG_BLANK;
            digitEn_q  <= '0;
            frame_q    <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            slotCnt_q  <= slotCnt_d;
            digitIdx_q <= digitIdx_d;
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            seg_q      <= seg_d;
            digitEn_q  <= digitEn_d;
            frame_q    <= frame_d;
            ready_q    <= ready_d;
        end
    end

    assign o_seg      = seg_q;
    assign o_digit_en = digitEn_q;
    assign o_frame    = frame_q;
    assign o_ready    = ready_q;

endmodule
